id_stage_pipe: RTL
==================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage: register-file read, control decode, sign extension, branch/jump resolution, and a registered ID/EX pipeline slot.
//  Adds over the previous decode stage: valid tracking, load-use hazard stall, flush bubble, parametrised width and register count, and an x0-zero register file.
//  Sits between the IF/ID register and the EX stage; drives PC-select back to fetch.
// PARAMETERS
//  XLEN    32  datapath width (>=32; instruction is always 32 bits)
//  NREG    32  architectural registers (power of 2, <=32); AW = $clog2(NREG)
// PORTS
//  Clk           in   1     clock; all state updates on posedge
//  Rst_n         in   1     reset, synchronous, active-low
//  In_Valid      in   1     IF/ID holds a real instruction
//  In_PC         in   XLEN  PC+4 of the instruction in ID
//  In_IR         in   32    instruction word
//  In_Flush      in   1     squash the ID instruction (bubble into ID/EX)
//  In_EXMemRead  in   1     instruction now in EX is a load
//  In_EXRt       in   5     destination of that load
//  In_Rd         in   5     writeback destination
//  In_WriteData  in   XLEN  writeback data
//  In_RegWrite   in   1     writeback enable
//  OutStall      out  1     comb: hold PC and IF/ID this cycle
//  OutBranchPC   out  XLEN  comb: In_PC + (SE<<2)
//  OutJumpPC     out  XLEN  comb: {In_PC[XLEN-1:28], In_IR[25:0], 2'b00}
//  OutPCSrc      out  1     comb: branch taken
//  OutJump       out  1     comb: jump
//  OutValid      out  1     reg: ID/EX slot valid
//  OutDataA/B    out  XLEN  reg: rs/rt read data
//  OutSE         out  XLEN  reg: sign-extended imm16
//  OutFunct      out  3     reg: ALU function
//  OutRs/Rt/Rd   out  5     reg: IR[25:21]/[20:16]/[15:11]
//  OutEXControl  out  4     reg: {ALUSrc, ALUOp[1:0], RegDst}
//  OutMEMControl out  2     reg: {MemWrite, MemRead}
//  OutWBControl  out  2     reg: {MemToReg, RegWrite}
// BEHAVIOUR
//  Reset (Rst_n=0 at posedge): all registered outputs 0; all NREG registers 0. Comb outputs follow the inputs.
//  Reg file: 2 async read ports, 1 write port at posedge. Index 0 always reads 0; writes to 0 are ignored. Index bits above AW are ignored.
//  Hazard: OutStall = In_Valid & In_EXMemRead & (In_EXRt!=0) & (In_EXRt==rs | In_EXRt==rt).
//  OutPCSrc = In_Valid & ~OutStall & ((Beq & A==B) | (Bne & A!=B)).
//  OutJump = In_Valid & ~OutStall & Jump.
//  ID/EX update, each posedge, one-cycle latency:
//   - bubble if In_Flush | OutStall | ~In_Valid: OutValid=0 and all control fields=0. Data fields may update (don't-care).
//   - otherwise capture decode, with OutValid=1.
//  Priority: Rst_n > In_Flush > OutStall > normal. A flush during a stall gives a bubble and deasserts neither OutStall nor the hold (IF owns that).
//  Arithmetic: SE = sign-extend imm16 to XLEN; branch target wraps modulo 2^XLEN.
//  Reset asserted mid-stall: next cycle OutValid=0 and OutStall is recomputed from the inputs.
// CONFIGURATION
//  ID_WB_BYPASS_EN defined: a read of In_Rd (!=0) with In_RegWrite=1 in the same cycle returns In_WriteData. This applies to data outputs and the branch comparator.
//  ID_WB_BYPASS_EN undefined: reads return the old register value; software or hazard logic must space the instructions apart.
// STRUCTURE
//  Shared package id_pkg: opcode/funct localparams, EX/MEM/WB control field widths and bit positions, ALUOp encodings.
//  Sub-module id_regfile (#XLEN, NREG): storage, x0 rule, optional bypass.
//  Control decode and hazard logic stay inline.
// TESTING
//  Reset: Rst_n=0 for 2 cycles -> OutValid=0, OutEXControl=0, OutWBControl=0; then reading r5 gives 0.
//  Write r3=0x1234 via WB, then add r4,r3,r3 -> next cycle OutDataA=OutDataB=0x1234, OutValid=1.
//  In_EXMemRead=1, In_EXRt=7, IR rs=7 -> OutStall=1 and the next OutValid=0. Same with In_EXRt=0 -> OutStall=0.
//  beq with r1=r2=5, In_PC=0x100, imm=4 -> OutPCSrc=1, OutBranchPC=0x110. Same with In_Valid=0 -> OutPCSrc=0.
//  In_Flush=1 on a valid sw -> next OutValid=0 and OutMEMControl=0. A write to r0 of 0xFFFF -> r0 still reads 0.
//  With ID_WB_BYPASS_EN: same-cycle write of r9=0xA5 and read of r9 -> OutDataA=0xA5. Without it -> old value.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, control-field layout and ALUOp codes,
// plus the opcode-to-control decode function.
package id_pkg;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam int unsigned ExCtrlW  = 4;
  localparam int unsigned MemCtrlW = 2;
  localparam int unsigned WbCtrlW  = 2;
  localparam int unsigned FunctW   = 3;

  localparam int unsigned ExAluSrcBit   = 3;
  localparam int unsigned ExAluOpHi     = 2;
  localparam int unsigned ExAluOpLo     = 1;
  localparam int unsigned ExRegDstBit   = 0;
  localparam int unsigned MemWriteBit   = 1;
  localparam int unsigned MemReadBit    = 0;
  localparam int unsigned WbMemToRegBit = 1;
  localparam int unsigned WbRegWriteBit = 0;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
    logic       beq;
    logic       bne;
    logic       jump;
  } ctrl_t;

  // Unknown opcodes decode to all-zero control (a valid no-op).
  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OpRType: begin
        c.alu_op    = AluOpFunct;
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      OpLw: begin
        c.alu_src    = 1'b1;
        c.alu_op     = AluOpAdd;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      OpSw: begin
        c.alu_src   = 1'b1;
        c.alu_op    = AluOpAdd;
        c.mem_write = 1'b1;
      end
      OpAddi: begin
        c.alu_src   = 1'b1;
        c.alu_op    = AluOpAdd;
        c.reg_write = 1'b1;
      end
      OpBeq: begin
        c.alu_op = AluOpSub;
        c.beq    = 1'b1;
      end
      OpBne: begin
        c.alu_op = AluOpSub;
        c.bne    = 1'b1;
      end
      OpJ:     c.jump = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: two async read ports, one synchronous write port, x0 hard-wired to zero.
// Define ID_WB_BYPASS_EN to forward same-cycle write data to the read ports.
module id_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      raddr_a_i,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            we_i
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [AW-1:0]   ra_a, ra_b, wa;
  logic            wr_en;

  assign ra_a  = raddr_a_i[AW-1:0];
  assign ra_b  = raddr_b_i[AW-1:0];
  assign wa    = waddr_i[AW-1:0];
  assign wr_en = we_i && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wdata_i;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata_a_o = (ra_a == '0) ? '0 : regs_q[ra_a];
    rdata_b_o = (ra_b == '0) ? '0 : regs_q[ra_b];
`ifdef ID_WB_BYPASS_EN
    if (wr_en && (wa == ra_a)) rdata_a_o = wdata_i;
    if (wr_en && (wa == ra_b)) rdata_b_o = wdata_i;
`endif
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register read, control decode, load-use stall, branch/jump resolution, ID/EX slot.
// Define ID_WB_BYPASS_EN to forward same-cycle writeback data into decode.
module id_stage_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            In_Valid,
  input  logic [XLEN-1:0] In_PC,
  input  logic [31:0]     In_IR,
  input  logic            In_Flush,
  input  logic            In_EXMemRead,
  input  logic [4:0]      In_EXRt,
  input  logic [4:0]      In_Rd,
  input  logic [XLEN-1:0] In_WriteData,
  input  logic            In_RegWrite,
  output logic            OutStall,
  output logic [XLEN-1:0] OutBranchPC,
  output logic [XLEN-1:0] OutJumpPC,
  output logic            OutPCSrc,
  output logic            OutJump,
  output logic            OutValid,
  output logic [XLEN-1:0] OutDataA,
  output logic [XLEN-1:0] OutDataB,
  output logic [XLEN-1:0] OutSE,
  output logic [2:0]      OutFunct,
  output logic [4:0]      OutRs,
  output logic [4:0]      OutRt,
  output logic [4:0]      OutRd,
  output logic [3:0]      OutEXControl,
  output logic [1:0]      OutMEMControl,
  output logic [1:0]      OutWBControl
);
  import id_pkg::*;

  logic [4:0]      rs, rt;
  logic [XLEN-1:0] rdata_a, rdata_b, se;
  ctrl_t           ctrl;
  logic            stall, bubble;

  logic                valid_q, valid_d;
  logic [XLEN-1:0]     data_a_q, data_a_d, data_b_q, data_b_d, se_q, se_d;
  logic [FunctW-1:0]   funct_q, funct_d;
  logic [4:0]          rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [ExCtrlW-1:0]  ex_ctrl_q, ex_ctrl_d;
  logic [MemCtrlW-1:0] mem_ctrl_q, mem_ctrl_d;
  logic [WbCtrlW-1:0]  wb_ctrl_q, wb_ctrl_d;

  assign rs = In_IR[25:21];
  assign rt = In_IR[20:16];

  id_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b),
    .waddr_i   (In_Rd),
    .wdata_i   (In_WriteData),
    .we_i      (In_RegWrite)
  );

  always_comb begin
    ctrl  = decode_op(In_IR[31:26]);
    se    = {{(XLEN-16){In_IR[15]}}, In_IR[15:0]};
    stall = In_Valid && In_EXMemRead && (In_EXRt != 5'd0) &&
            ((In_EXRt == rs) || (In_EXRt == rt));
    // Flush wins over stall only for the ID/EX slot; the stall itself still goes to fetch.
    bubble = In_Flush || stall || !In_Valid;
  end

  assign OutStall    = stall;
  assign OutPCSrc    = In_Valid && !stall &&
                       ((ctrl.beq && (rdata_a == rdata_b)) || (ctrl.bne && (rdata_a != rdata_b)));
  assign OutJump     = In_Valid && !stall && ctrl.jump;
  assign OutBranchPC = In_PC + (se << 2);
  assign OutJumpPC   = {In_PC[XLEN-1:28], In_IR[25:0], 2'b00};

  always_comb begin
    valid_d    = 1'b0;
    ex_ctrl_d  = '0;
    mem_ctrl_d = '0;
    wb_ctrl_d  = '0;
    data_a_d   = rdata_a;
    data_b_d   = rdata_b;
    se_d       = se;
    funct_d    = In_IR[FunctW-1:0];
    rs_d       = rs;
    rt_d       = rt;
    rd_d       = In_IR[15:11];
    if (!bubble) begin
      valid_d                           = 1'b1;
      ex_ctrl_d[ExAluSrcBit]            = ctrl.alu_src;
      ex_ctrl_d[ExAluOpHi:ExAluOpLo]    = ctrl.alu_op;
      ex_ctrl_d[ExRegDstBit]            = ctrl.reg_dst;
      mem_ctrl_d[MemWriteBit]           = ctrl.mem_write;
      mem_ctrl_d[MemReadBit]            = ctrl.mem_read;
      wb_ctrl_d[WbMemToRegBit]          = ctrl.mem_to_reg;
      wb_ctrl_d[WbRegWriteBit]          = ctrl.reg_write;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      valid_q    <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      se_q       <= '0;
      funct_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      ex_ctrl_q  <= '0;
      mem_ctrl_q <= '0;
      wb_ctrl_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      se_q       <= se_d;
      funct_q    <= funct_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      wb_ctrl_q  <= wb_ctrl_d;
    end
  end

  assign OutValid      = valid_q;
  assign OutDataA      = data_a_q;
  assign OutDataB      = data_b_q;
  assign OutSE         = se_q;
  assign OutFunct      = funct_q;
  assign OutRs         = rs_q;
  assign OutRt         = rt_q;
  assign OutRd         = rd_q;
  assign OutEXControl  = ex_ctrl_q;
  assign OutMEMControl = mem_ctrl_q;
  assign OutWBControl  = wb_ctrl_q;

endmodule
